exp_arbiter: RTL and testbench

- Shares one exp Taylor-series pipeline (5.10 fixed point, 16-bit signed, free-running, no valid/ready) between two requesters.
- Round-robin arbitration on a valid/ready request side.
- Tracks in-flight samples with a tag delay line matched to the pipeline latency.
- Steers each result into a per-requester result FIFO with valid/ready; credit counting prevents result loss, since the pipeline cannot stall.

---
 rtl/exp_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_exp_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_arbiter.sv
// exp_arbiter: round-robin sharing of one exp pipeline between two requesters.
// Optional macro EXP_CLAMP_EN: clamp granted samples to +/-2.0, sticky clamp_seen.
module exp_arbiter #(
  parameter int EXP_LAT    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_data,
  output logic        res0_valid,
  input  logic        res0_ready,
  output logic [15:0] res0_data,
  output logic        res1_valid,
  input  logic        res1_ready,
  output logic [15:0] res1_data,
  output logic [15:0] exp_data,
  input  logic [15:0] exp_result,
  output logic        busy,
  output logic        clamp_seen
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [1:0]         rv;
  logic [1:0]         elig;
  logic [1:0]         gnt;
  logic [1:0]         push;
  logic [1:0]         pop;
  logic [1:0]         fne;
  logic               win;
  logic               gany;
  logic               rr_q;
  logic [15:0]        raw;
  logic [15:0]        smp;
  logic [CW-1:0]      cnt_q [2];
  logic [CW-1:0]      cnt_d [2];
  logic [EXP_LAT-1:0] tv_q;
  logic [EXP_LAT-1:0] tid_q;
  logic [15:0]        mem_q [2][FIFO_DEPTH];
  logic [AW-1:0]      wp_q  [2];
  logic [AW-1:0]      rp_q  [2];
  logic [CW-1:0]      fc_q  [2];

  assign rv      = {req1_valid, req0_valid};
  assign elig[0] = rv[0] && (cnt_q[0] != FULL);
  assign elig[1] = rv[1] && (cnt_q[1] != FULL);

  // Round-robin grant; no grant while reset is held
  always_comb begin
    gnt = 2'b00;
    win = 1'b0;
    if (!RST) begin
      if (&elig) begin
        win = rr_q;
        gnt = rr_q ? 2'b10 : 2'b01;
      end else if (elig[0]) begin
        gnt = 2'b01;
      end else if (elig[1]) begin
        gnt = 2'b10;
        win = 1'b1;
      end
    end
  end

  assign gany       = |gnt;
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign raw        = win ? req1_data : req0_data;

`ifdef EXP_CLAMP_EN
  logic clip;
  logic clamp_q;

  // Saturate the granted sample to [-2.0, +2.0]
  always_comb begin
    smp  = raw;
    clip = 1'b0;
    if ($signed(raw) > $signed(16'h0800)) begin
      smp  = 16'h0800;
      clip = 1'b1;
    end else if ($signed(raw) < $signed(16'hF800)) begin
      smp  = 16'hF800;
      clip = 1'b1;
    end
  end

  // Sticky record of any clamp on a granted sample
  always_ff @(posedge CLK) begin
    if (RST) begin
      clamp_q <= 1'b0;
    end else if (gany && clip) begin
      clamp_q <= 1'b1;
    end
  end

  assign clamp_seen = clamp_q;
`else
  assign smp        = raw;
  assign clamp_seen = 1'b0;
`endif

  assign exp_data = gany ? smp : 16'h0000;

  assign push[0] = tv_q[EXP_LAT-1] && !tid_q[EXP_LAT-1];
  assign push[1] = tv_q[EXP_LAT-1] &&  tid_q[EXP_LAT-1];

  assign fne[0]  = fc_q[0] != '0;
  assign fne[1]  = fc_q[1] != '0;
  assign pop[0]  = fne[0] && res0_ready;
  assign pop[1]  = fne[1] && res1_ready;

  assign res0_valid = fne[0];
  assign res1_valid = fne[1];
  assign res0_data  = fne[0] ? mem_q[0][rp_q[0]] : 16'h0000;
  assign res1_data  = fne[1] ? mem_q[1][rp_q[1]] : 16'h0000;

  // Credit next-state: grant reserves a slot, pop releases it
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i];
      if (gnt[i] && !pop[i]) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (!gnt[i] && pop[i]) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
  end

  // Credit counters and round-robin pointer
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      rr_q     <= 1'b0;
    end else begin
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      if (gany) begin
        rr_q <= ~win;
      end
    end
  end

  // Tag delay line tracking which requester owns each pipeline slot
  always_ff @(posedge CLK) begin
    if (RST) begin
      tv_q  <= '0;
      tid_q <= '0;
    end else begin
      tv_q[0]  <= gany;
      tid_q[0] <= win;
      for (int k = 1; k < EXP_LAT; k++) begin
        tv_q[k]  <= tv_q[k-1];
        tid_q[k] <= tid_q[k-1];
      end
    end
  end

  // Result FIFO pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 2; i++) begin
        wp_q[i] <= '0;
        rp_q[i] <= '0;
        fc_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          wp_q[i] <= wp_q[i] + AW'(1);
        end
        if (pop[i]) begin
          rp_q[i] <= rp_q[i] + AW'(1);
        end
        if (push[i] && !pop[i]) begin
          fc_q[i] <= fc_q[i] + CW'(1);
        end else if (!push[i] && pop[i]) begin
          fc_q[i] <= fc_q[i] - CW'(1);
        end
      end
    end
  end

  // Result FIFO storage; contents are masked while empty
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        mem_q[i][wp_q[i]] <= exp_result;
      end
    end
  end

  assign busy = (cnt_q[0] != '0) || (cnt_q[1] != '0);

endmodule

// File: tb/tb_exp_arbiter.sv
// tb_exp_arbiter: randomized scoreboard bench with a stub exp (delay of data+1).
// Reference model tracks per-requester outstanding samples as timed queues.
module tb_exp_arbiter;

  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [15:0] req0_data = '0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [15:0] req1_data = '0;
  logic        res0_valid;
  logic        res0_ready = 1'b0;
  logic [15:0] res0_data;
  logic        res1_valid;
  logic        res1_ready = 1'b0;
  logic [15:0] res1_data;
  logic [15:0] exp_data;
  logic [15:0] exp_result;
  logic        busy;
  logic        clamp_seen;

  exp_arbiter #(.EXP_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .res0_valid(res0_valid), .res0_ready(res0_ready), .res0_data(res0_data),
    .res1_valid(res1_valid), .res1_ready(res1_ready), .res1_data(res1_data),
    .exp_data(exp_data), .exp_result(exp_result),
    .busy(busy), .clamp_seen(clamp_seen)
  );

  always #5 CLK = ~CLK;

  // Stub exp: LAT-deep delay of data+1, reset with the arbiter
  logic [15:0] pipe [LAT];
  always @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= exp_data + 16'd1;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign exp_result = pipe[LAT-1];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mclamp(input logic [15:0] x);
`ifdef EXP_CLAMP_EN
    int v;
    v = int'($signed(x));
    if (v > 2048) return 16'h0800;
    if (v < -2048) return 16'hF800;
`endif
    return x;
  endfunction

  typedef struct {
    logic [15:0] d;
    int          av;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  bit   m_rr    = 1'b0;
  bit   m_clamp = 1'b0;
  bit   last_rst = 1'b1;

  // Model of acceptance: credit = outstanding entries, RR on ties
  always @(negedge CLK) begin
    bit e0, e1, g0, g1;
    logic [15:0] xd;
    if (RST) begin
      chk("ready0_in_reset", req0_ready, 0);
      chk("ready1_in_reset", req1_ready, 0);
      q0.delete();
      q1.delete();
      m_rr    = 1'b0;
      m_clamp = 1'b0;
    end else begin
      e0 = req0_valid && (q0.size() < DEPTH);
      e1 = req1_valid && (q1.size() < DEPTH);
      if (e0 && e1) begin
        g0 = !m_rr;
        g1 = m_rr;
      end else begin
        g0 = e0;
        g1 = e1;
      end
      chk("req0_ready", req0_ready, g0);
      chk("req1_ready", req1_ready, g1);
      chk("busy", busy, (q0.size() + q1.size()) != 0);
      chk("clamp_seen", clamp_seen, m_clamp);
      xd = g0 ? mclamp(req0_data) : (g1 ? mclamp(req1_data) : 16'h0000);
      chk("exp_data", exp_data, xd);
      if (g0) begin
        q0.push_back('{mclamp(req0_data) + 16'd1, cyc + LAT + 1});
        if (mclamp(req0_data) != req0_data) m_clamp = 1'b1;
        m_rr = 1'b1;
      end
      if (g1) begin
        q1.push_back('{mclamp(req1_data) + 16'd1, cyc + LAT + 1});
        if (mclamp(req1_data) != req1_data) m_clamp = 1'b1;
        m_rr = 1'b0;
      end
    end
  end

  // Result monitor: pops the scoreboard whenever a result is consumed
  always @(negedge CLK) begin
    bit ev0, ev1;
    #2;
    if (!RST) begin
      ev0 = (q0.size() > 0) && (q0[0].av <= cyc);
      ev1 = (q1.size() > 0) && (q1[0].av <= cyc);
      chk("res0_valid", res0_valid, ev0);
      chk("res1_valid", res1_valid, ev1);
      if (last_rst) begin
        chk("res0_data_after_reset", res0_data, 16'h0000);
        chk("res1_data_after_reset", res1_data, 16'h0000);
      end
      if (ev0 && res0_valid) begin
        chk("res0_data", res0_data, q0[0].d);
        if (res0_ready) void'(q0.pop_front());
      end
      if (ev1 && res1_valid) begin
        chk("res1_data", res1_data, q1[0].d);
        if (res1_ready) void'(q1.pop_front());
      end
    end
    last_rst = RST;
  end

  task automatic step(output bit h0, output bit h1);
    @(negedge CLK);
    h0 = req0_valid && req0_ready;
    h1 = req1_valid && req1_ready;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    bit a, b;
    for (int i = 0; i < n; i++) step(a, b);
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    idle(n);
    RST = 1'b0;
  endtask

  initial begin
    bit h0, h1;
    int k;
    @(posedge CLK);
    #1;
    do_reset(3);

    // Single sample, first-result latency
    res0_ready = 1'b1;
    res1_ready = 1'b1;
    req0_valid = 1'b1;
    req0_data  = 16'h0010;
    step(h0, h1);
    req0_valid = 1'b0;
    idle(8);

    // Both streaming after reset: alternation starting with 0
    do_reset(2);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 16'd100;
    req1_data  = 16'd200;
    for (int i = 0; i < 40; i++) begin
      step(h0, h1);
      if (h0) req0_data = req0_data + 16'd1;
      if (h1) req1_data = req1_data + 16'd1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    idle(10);

    // Back-pressure on result 0: credit stops req0 at DEPTH
    res0_ready = 1'b0;
    req0_valid = 1'b1;
    req0_data  = 16'd1;
    for (int i = 0; i < 42; i++) begin
      if (i == 12) res0_ready = 1'b1;
      req1_valid = 1'($urandom_range(0, 1));
      req1_data  = 16'($urandom);
      step(h0, h1);
      if (h0) req0_data = req0_data + 16'd1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    idle(10);

    // Random traffic, including out-of-range samples
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      res0_ready = ($urandom_range(0, 2) != 0);
      res1_ready = ($urandom_range(0, 2) != 0);
      req0_data  = 16'($urandom);
      req1_data  = 16'($urandom);
      step(h0, h1);
    end

    // Drain with a bounded wait
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res0_ready = 1'b1;
    res1_ready = 1'b1;
    k = 0;
    while (k < 50 && (q0.size() + q1.size()) != 0) begin
      step(h0, h1);
      k++;
    end
    chk("drain_outstanding", 16'(q0.size() + q1.size()), 16'd0);

    // Reset with samples in flight: nothing may emerge afterwards
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 16'h0123;
    req1_data  = 16'h0456;
    idle(3);
    RST = 1'b1;
    step(h0, h1);
    RST = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    idle(10);

    // Out-of-range samples: clamped only when the feature is built in
    req0_valid = 1'b1;
    req0_data  = 16'h1000;
    step(h0, h1);
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_data  = 16'hE000;
    step(h0, h1);
    req1_valid = 1'b0;
    idle(8);
    do_reset(1);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
